booth_seq_mult: RTL and testbench
=================================

BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand width in bits; W is even and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply, sampled on the rising edge.
REQ-005 The block SHALL have port a, input, W bits: signed two's-complement multiplicand, sampled with start.
REQ-006 The block SHALL have port b, input, W bits: signed two's-complement multiplier, sampled with start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is in progress (states RUN and DONE).
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that product is valid.
REQ-009 The block SHALL have port product, output, 2W bits: signed product, held until the next accepted start.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-011 In IDLE with start=1, the block SHALL latch a and b, clear the accumulator and the digit index i, and enter RUN.
REQ-012 start SHALL be ignored in RUN and DONE, and a and b SHALL NOT be re-sampled then.
REQ-013 In RUN, each cycle SHALL process radix-4 digit i (0..W/2-1) from triplet {b[2i+1], b[2i], b[2i-1]}, where b[-1]=0.
REQ-014 The digit map SHALL be: 000/111 -> 0; 001/010 -> +a; 011 -> +2a; 100 -> -2a; 101/110 -> -a.
REQ-015 The partial product SHALL be formed at W+2 bits, so that -2a at a=-2^(W-1) does not wrap.
REQ-016 The partial product SHALL be sign-extended to 2W bits, shifted left by 2i, and added to the accumulator modulo 2^(2W).
REQ-017 After digit W/2-1 is processed, the block SHALL load product with the final accumulator value on the same edge and enter DONE.
REQ-018 DONE SHALL last exactly one cycle, with done=1, and then return to IDLE.
REQ-019 Latency SHALL be W/2 cycles: for W=8, done is high in the 4th cycle after the edge that sampled start.
REQ-020 product SHALL change only on the edge that enters DONE, or on reset.
REQ-021 A start that is high during DONE SHALL be ignored; back-to-back operations require start in IDLE, giving a minimum period of W/2+2 cycles.

Reset
REQ-022 When rst_n=0, the block SHALL immediately force state IDLE, busy=0, done=0, product=0, accumulator=0, i=0, and the latched operands to 0.
REQ-023 A reset during RUN or DONE SHALL abort the operation, with no done pulse, and the block SHALL accept a new start on the first edge after rst_n rises.

Configuration
REQ-024 With macro BOOTH_ZERO_SKIP_EN defined, the block SHALL move RUN -> DONE early after digit i when i < W/2-1 and b[W-1:2i+1] is all-zeros or all-ones (all remaining digits are 0); product then equals the full result and latency is 1..W/2 cycles.
REQ-025 Without BOOTH_ZERO_SKIP_EN, the block SHALL always process all W/2 digits, with fixed latency.

Structure
REQ-026 Package booth_pkg SHALL hold the FSM state enum, the radix-4 digit typedef (ZERO, POS1, POS2, NEG1, NEG2), and the digit-map function.
REQ-027 Sub-module booth_pp_gen SHALL be combinational: inputs are the W-bit multiplicand and a 3-bit triplet; output is the (W+2)-bit signed partial product.
REQ-028 The FSM, index counter, accumulator and product register SHALL reside in booth_seq_mult.

Verification
REQ-029 The bench SHALL cover: W=8, a=7, b=3, start for 1 cycle -> done in the 4th cycle, product=0x0015, busy high for 5 cycles.
REQ-030 The bench SHALL cover: a=-128, b=-128 -> product=0x4000 (exercises -2a at the most negative a).
REQ-031 The bench SHALL cover: a=-128, b=127 -> product=0xC080; then a=0, b=-1 -> product=0x0000.
REQ-032 The bench SHALL cover: start held high throughout RUN with changing a/b -> the result uses the first-sampled operands, there is exactly one done, and the next operation starts only from IDLE.
REQ-033 The bench SHALL cover: rst_n pulsed low in the 2nd RUN cycle -> busy=0, done=0 and product=0 immediately; no done follows; a new 5x5 operation then gives 0x0019.
REQ-034 The bench SHALL cover, with BOOTH_ZERO_SKIP_EN: a=5, b=1 -> done in the 1st cycle, product=0x0005; a=5, b=-1 -> done in the 1st cycle, product=0xFFFB.

Source files
------------

// File: rtl/booth_pkg.sv
// ----------------------------------------------------------------------------
// booth_pkg
//   Shared types and helpers for the radix-4 Booth sequential multiplier.
//   - state_t     : controller states (IDLE, RUN, DONE)
//   - digit_t     : recoded radix-4 Booth digit (ZERO, POS1, POS2, NEG1, NEG2)
//   - booth_digit : maps a multiplier triplet {b[2i+1], b[2i], b[2i-1]}
//                   to its Booth digit
// ----------------------------------------------------------------------------
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } digit_t;

    function automatic digit_t booth_digit(input logic [2:0] trip);
        digit_t d;
        case (trip)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;  // 000 and 111
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// ----------------------------------------------------------------------------
// booth_pp_gen
//   Combinational radix-4 Booth partial-product generator.
//   Ports:
//     a    in  [W-1:0]  signed multiplicand
//     trip in  [2:0]    multiplier triplet {b[2i+1], b[2i], b[2i-1]}
//     pp   out [W+1:0]  signed partial product (0, +-a, +-2a)
//   The result is two bits wider than the multiplicand so that -2a at the
//   most negative a (e.g. +256 for W=8) is still representable.
// ----------------------------------------------------------------------------
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]        a,
    input  logic [2:0]          trip,
    output logic signed [W+1:0] pp
);

    logic signed [W+1:0] a_ext;

    assign a_ext = {{2{a[W-1]}}, a};

    always_comb begin
        // NOTE: default assignment first so no path leaves pp unassigned
        // (which would infer a latch).
        pp = '0;
        case (booth_digit(trip))
            POS1:    pp = a_ext;
            POS2:    pp = a_ext <<< 1;
            NEG1:    pp = -a_ext;
            NEG2:    pp = -(a_ext <<< 1);
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_seq_mult.sv
// ----------------------------------------------------------------------------
// booth_seq_mult
//   Sequential signed radix-4 Booth multiplier, one digit per clock.
//   Ports:
//     clk     in           rising-edge clock
//     rst_n   in           asynchronous active-low reset
//     start   in           begin a multiply (accepted in IDLE only)
//     a       in  [W-1:0]  signed multiplicand, sampled with start
//     b       in  [W-1:0]  signed multiplier, sampled with start
//     busy    out          high in RUN and DONE
//     done    out          one-cycle pulse, product valid
//     product out [2W-1:0] signed product, held until the next result
//   Configuration macro:
//     BOOTH_ZERO_SKIP_EN  finish early once every remaining digit is zero
//                         (latency 1..W/2); undefined = fixed W/2 cycles.
// ----------------------------------------------------------------------------
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int ND = W / 2;
    localparam int IW = (ND > 1) ? $clog2(ND) : 1;

    state_t              state;
    logic [W-1:0]        a_reg;
    logic [W-1:0]        b_reg;
    logic [2*W-1:0]      acc;
    logic [IW-1:0]       idx;

    logic [W:0]          b_ext;
    logic [2:0]          trip;
    logic signed [W+1:0] pp;
    logic [2*W-1:0]      pp_ext;
    logic [2*W-1:0]      pp_sh;
    logic [2*W-1:0]      acc_next;
    logic                last;
    logic                skip;

    // Appending b[-1]=0 lets digit i read its triplet at bit offset 2i.
    assign b_ext = {b_reg, 1'b0};
    assign trip  = 3'(b_ext >> {idx, 1'b0});

    booth_pp_gen #(.W(W)) u_pp_gen (
        .a    (a_reg),
        .trip (trip),
        .pp   (pp)
    );

    assign pp_ext   = {{(W-2){pp[W+1]}}, pp};
    assign pp_sh    = pp_ext << {idx, 1'b0};
    assign acc_next = acc + pp_sh;
    assign last     = (idx == IW'(ND - 1));

`ifdef BOOTH_ZERO_SKIP_EN
    // Bits b[W-1:2i+1] feed every remaining triplet; if they are all equal
    // every remaining digit is zero and the accumulator is already final.
    logic signed [W-1:0] rest;
    assign rest = $signed(b_reg) >>> {idx, 1'b1};
    assign skip = !last && ((rest == '0) || (rest == '1));
`else
    assign skip = 1'b0;
`endif

    // NOTE: all state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    idx <= idx + IW'(1);
                    if (last || skip) begin
                        product <= acc_next;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_mult.sv
// ----------------------------------------------------------------------------
// tb_booth_seq_mult
//   Scoreboard bench for booth_seq_mult (W=8). Stimulus pushes the expected
//   product and latency; a negedge monitor pops and compares on every done.
//   Latency expectations follow BOOTH_ZERO_SKIP_EN when it is defined.
// ----------------------------------------------------------------------------
module tb_booth_seq_mult;

    localparam int W = 8;
`ifdef BOOTH_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    booth_seq_mult #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] prod;
        int             start_cyc;
        int             lat;
        string          name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Cycles from the accepting edge to the edge that raises done.
    function automatic int exp_lat(input logic [W-1:0] bv);
        logic signed [W-1:0] r;
        if (!SKIP) return W / 2;
        for (int i = 0; i < W / 2 - 1; i++) begin
            r = $signed(bv) >>> (2 * i + 1);
            if (r == 0 || r == -1) return i + 1;
        end
        return W / 2;
    endfunction

    // Drive start with operands (at a negedge) and record the expectation.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [2*W-1:0] pe, input string nm);
        exp_t e;
        start       = 1'b1;
        a           = av;
        b           = bv;
        e.prod      = pe;
        e.start_cyc = cyc + 1;
        e.lat       = exp_lat(bv);
        e.name      = nm;
        sb.push_back(e);
    endtask

    task automatic wait_idle(output int bc);
        bit idle;
        idle = 1'b0;
        bc   = 0;
        for (int k = 0; k < 40 && !idle; k++) begin
            if (busy) begin
                bc++;
                @(negedge clk);
            end else begin
                idle = 1'b1;
            end
        end
        if (!idle) begin
            total++;
            bad++;
            $display("FAIL wait_idle busy still high after 40 cycles");
        end
    endtask

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [2*W-1:0] pe, input string nm, output int bc);
        @(negedge clk);
        issue(av, bv, pe, nm);
        @(negedge clk);
        start = 1'b0;
        wait_idle(bc);
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done product=0x%0h with no operation pending", product);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_product"}, 32'(product), 32'(e.prod));
                check({e.name, "_latency"}, 32'(cyc - e.start_cyc), 32'(e.lat));
            end
        end
    end

    initial begin
        int bc;
        bit idle;
        start = 1'b0;
        a     = '0;
        b     = '0;
        rst_n = 1'b0;
        #12;
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_product", 32'(product), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Basic operation, latency and busy width.
        run_op(8'd7, 8'd3, 16'h0015, "a7_b3", bc);
        check("a7_b3_busy_cycles", 32'(bc), 32'(exp_lat(8'd3) + 1));

        // Boundary and sign patterns.
        run_op(8'h80, 8'h80, 16'h4000, "m128_m128", bc);
        run_op(8'h80, 8'h7F, 16'hC080, "m128_p127", bc);
        run_op(8'h00, 8'hFF, 16'h0000, "zero_m1", bc);
        run_op(8'hFD, 8'h07, 16'hFFEB, "m3_p7", bc);
        run_op(8'd100, 8'hCE, 16'hEC78, "p100_m50", bc);
        run_op(8'h7F, 8'h7F, 16'h3F01, "p127_p127", bc);
        run_op(8'd5, 8'd1, 16'h0005, "p5_p1", bc);
        run_op(8'd5, 8'hFF, 16'hFFFB, "p5_m1", bc);

        // Product holds while idle with changing inputs and start low.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a = 8'(k * 29 + 3);
            b = 8'(k * 71 + 9);
        end
        @(negedge clk);
        check("hold_product", 32'(product), 32'h0000FFFB);
        check("hold_busy", 32'(busy), 32'(0));

        // start held high through RUN/DONE with changing operands.
        @(negedge clk);
        issue(8'd3, 8'd4, 16'h000C, "held_first");
        idle = 1'b0;
        for (int k = 0; k < 40 && !idle; k++) begin
            @(negedge clk);
            if (busy) begin
                a = 8'(k * 37 + 11);
                b = 8'(k * 53 + 5);
            end else begin
                idle = 1'b1;
            end
        end
        if (!idle) begin
            total++;
            bad++;
            $display("FAIL held_start busy never dropped");
        end
        issue(8'd2, 8'd9, 16'h0012, "held_second");
        @(negedge clk);
        start = 1'b0;
        wait_idle(bc);

        // Reset in the 2nd RUN cycle aborts without a done pulse.
        @(negedge clk);
        start = 1'b1;
        a     = 8'd5;
        b     = 8'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_product", 32'(product), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'd5, 8'd5, 16'h0019, "after_reset");
        @(negedge clk);
        start = 1'b0;
        wait_idle(bc);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
